// File: rtl/chunked_compare_if.sv
// Operand/result handshake bundle for chunked_compare.
// The requester drives operands and out_ready; the compare unit answers with ready/valid and the result.
interface chunked_compare_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             illegal_op;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, illegal_op
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, illegal_op
  );
endinterface

// File: rtl/chunked_compare.sv
// Multi-cycle magnitude/equality comparator: scans CHUNK bits per cycle from the MSB down
// and stops at the first differing chunk, producing an SLT-style {0..0, flag} result.
module chunked_compare #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input logic            clk,
  input logic            rst_n,
  chunked_compare_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [2:0] OP_LTU = 3'b000;
  localparam logic [2:0] OP_LT  = 3'b001;
  localparam logic [2:0] OP_GEU = 3'b010;
  localparam logic [2:0] OP_GE  = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;
  localparam logic [2:0] OP_NE  = 3'b101;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("chunked_compare: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [IDX_W-1:0] idx;
  logic             flag_q;
  logic             illegal_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             is_signed;
  logic             chunk_lt;
  logic             chunk_eq;
  logic             flag_next;
  logic             op_illegal;

  assign is_signed  = (op_q == OP_LT) || (op_q == OP_GE);
  assign op_illegal = op_q[2] & op_q[1];

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so a single unsigned chunk comparator serves both signednesses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_chunk = a_q[CHUNK*int'(idx) +: CHUNK];
    b_chunk = b_q[CHUNK*int'(idx) +: CHUNK];
    if (is_signed && (idx == IDX_W'(NCHUNK - 1))) begin
      a_chunk[CHUNK-1] = ~a_chunk[CHUNK-1];
      b_chunk[CHUNK-1] = ~b_chunk[CHUNK-1];
    end
  end

  assign chunk_lt = (a_chunk < b_chunk);
  assign chunk_eq = (a_chunk == b_chunk);

  // At the finishing edge lt/eq equal chunk_lt/chunk_eq in both exit cases
  // (differing chunk, or all chunks equal with lt=0).
  always_comb begin
    flag_next = 1'b0;
    unique case (op_q)
      OP_LTU, OP_LT: flag_next = chunk_lt;
      OP_GEU, OP_GE: flag_next = ~chunk_lt;
      OP_EQ:         flag_next = chunk_eq;
      OP_NE:         flag_next = ~chunk_eq;
      default:       flag_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the captured operands are plain registers, not a RAM, so they are reset along with the FSM.
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx       <= '0;
      flag_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            op_q  <= bus.op;
            idx   <= IDX_W'(NCHUNK - 1);
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!chunk_eq || (idx == '0)) begin
            flag_q    <= op_illegal ? 1'b0 : flag_next;
            illegal_q <= op_illegal;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.result     = {{(WIDTH-1){1'b0}}, flag_q};
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_chunked_compare.sv
// Self-checking bench for chunked_compare: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_chunked_compare;
  localparam int WIDTH  = 64;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB1 = {1'b1, {(WIDTH-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  chunked_compare_if #(.WIDTH(WIDTH)) bus ();

  chunked_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  bit   inflight = 1'b0;
  logic exp_flag = 1'b0;
  logic exp_ill  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: flag from native integer compares; latency from the most significant
  // chunk in which the operands differ.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [2:0] op, output logic flag,
                                output logic ill, output int k);
    logic [WIDTH-1:0] diff;
    diff = a ^ b;
    k = NCHUNK;
    for (int i = NCHUNK - 1; i >= 0; i--)
      if ((diff >> (WIDTH - CHUNK * (i + 1))) != '0) k = i + 1;
    ill = 1'b0;
    case (op)
      3'd0:    flag = (a < b);
      3'd1:    flag = ($signed(a) < $signed(b));
      3'd2:    flag = (a >= b);
      3'd3:    flag = ($signed(a) >= $signed(b));
      3'd4:    flag = (a == b);
      3'd5:    flag = (a != b);
      default: begin flag = 1'b0; ill = 1'b1; end
    endcase
  endfunction

  // Whenever a result is presented it must match the model; with nothing in flight no result may appear.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inflight && bus.out_valid) begin
        check("mon_result", bus.result, {{(WIDTH-1){1'b0}}, exp_flag});
        check("mon_illegal", 64'(bus.illegal_op), 64'(exp_ill));
        check("mon_in_ready", 64'(bus.in_ready), 64'd0);
      end else if (!inflight) begin
        check("mon_idle_valid", 64'(bus.out_valid), 64'd0);
      end
    end
  end

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] op, input int hold,
                       input int lit_k = -1, input int lit_flag = -1, input int lit_ill = -1);
    logic f, il;
    int   k, cnt;
    model(a, b, op, f, il, k);
    if (lit_k >= 0)    check("model_k", 64'(k), 64'(lit_k));
    if (lit_flag >= 0) check("model_flag", 64'(f), 64'(lit_flag));
    if (lit_ill >= 0)  check("model_ill", 64'(il), 64'(lit_ill));
    exp_flag = f;
    exp_ill  = il;
    check("accept_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.out_ready = 1'($urandom);
    inflight      = 1'b1;
    @(negedge clk);
    cnt = 0;
    do begin
      bus.in_valid  = 1'($urandom);
      bus.a         = {$urandom, $urandom};
      bus.b         = {$urandom, $urandom};
      bus.op        = 3'($urandom);
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      cnt++;
    end while (!bus.out_valid && cnt < NCHUNK + 2);
    bus.out_ready = 1'b0;
    check("latency", 64'(cnt), 64'(k));
    check("out_valid", 64'(bus.out_valid), 64'd1);
    if (lit_flag >= 0) check("dut_result", bus.result, 64'(lit_flag));
    if (lit_ill >= 0)  check("dut_illegal", 64'(bus.illegal_op), 64'(lit_ill));
    repeat (hold) begin
      bus.in_valid = 1'($urandom);
      bus.a        = {$urandom, $urandom};
      bus.op       = 3'($urandom);
      @(negedge clk);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    // in_valid high on the release edge must not start a new operation.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    inflight = 1'b0;
    check("release_out_valid", 64'(bus.out_valid), 64'd0);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] pick_extreme();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return ALL1;
      2:       return MSB1;
      default: return ~MSB1;
    endcase
  endfunction

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int               sel;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_illegal", 64'(bus.illegal_op), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases with hand-computed expectations.
    do_op(64'd5, 64'd10, 3'b000, 1, 8, 1, 0);
    do_op(64'd10, 64'd5, 3'b000, 0, 8, 0, 0);
    do_op(MSB1, MSB1 | 64'd1, 3'b000, 0, 8, 1, 0);
    do_op(MSB1, MSB1 | 64'd1, 3'b001, 0, 8, 1, 0);
    do_op(ALL1, 64'd0, 3'b000, 0, 1, 0, 0);
    do_op(ALL1, 64'd0, 3'b001, 0, 1, 1, 0);
    do_op(ALL1, 64'd0, 3'b011, 0, 1, 0, 0);
    do_op(ALL1, ALL1, 3'b100, 0, 8, 1, 0);
    do_op(ALL1, ALL1, 3'b101, 0, 8, 0, 0);
    do_op(MSB1, ~MSB1, 3'b001, 0, 1, 1, 0);
    do_op(MSB1, ~MSB1, 3'b010, 0, 1, 1, 0);
    // Backpressure: result held for 5 cycles with in_valid pulses ignored.
    do_op(64'h0000_0100_0000_0000, 64'h0000_0200_0000_0000, 3'b010, 5, 3, 0, 0);

    // Randomized operations.
    for (int n = 0; n < 300; n++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      sel = $urandom_range(0, 4);
      case (sel)
        1: rb = ra;
        2: rb = ra ^ (64'd1 << $urandom_range(0, WIDTH - 1));
        3: begin ra = pick_extreme(); rb = pick_extreme(); end
        4: begin
          rb = ra;
          rb[CHUNK * $urandom_range(0, NCHUNK - 1) +: CHUNK] = 8'($urandom);
        end
        default: ;
      endcase
      do_op(ra, rb, 3'($urandom), $urandom_range(0, 3));
    end

    // Reset mid-scan aborts the operation; the first accept after release is immediate.
    bus.in_valid = 1'b1;
    bus.a        = 64'd7;
    bus.b        = 64'd7;
    bus.op       = 3'b100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midscan_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midscan_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midscan_rst_result", bus.result, 64'd0);
    repeat (3) begin
      bus.in_valid = 1'($urandom);
      @(negedge clk);
      check("in_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("in_rst_in_ready", 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    do_op(64'd3, 64'd9, 3'b110, 2, 8, 0, 1);
    do_op(ALL1, 64'd1, 3'b111, 0, 1, 0, 1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
